// File: rtl/speech_arbiter_if.sv
// Talker handshake bundle: request/address/source/error toward the talker, busy level back from it.
interface speech_arbiter_if;
    logic        talk_req;
    logic [15:0] talk_addr;
    logic [1:0]  grant_src;
    logic        timeout_err;
    logic        talk_busy;

    modport master (
        output talk_req,
        output talk_addr,
        output grant_src,
        output timeout_err,
        input  talk_busy
    );

    modport slave (
        input  talk_req,
        input  talk_addr,
        input  grant_src,
        input  timeout_err,
        output talk_busy
    );
endinterface

// File: rtl/speech_arbiter.sv
// Priority arbiter for the single phrase-playback channel: captures alarm/action/emotion/chatter
// events, grants one at a time over a req/busy handshake and enforces a cooldown between phrases.
//
// state  | meaning
// S_IDLE | channel free; grant highest-priority pending source
// S_REQ  | talk_req high, waiting for synchronized busy (bounded by REQ_TIMEOUT)
// S_BUSY | talker playing; wait for busy to drop
// S_COOL | enforced silence, cool_cnt counting down to 0
module speech_arbiter #(
    parameter int COOLDOWN    = 10,
    parameter int PERIODIC    = 64,
    parameter int REQ_TIMEOUT = 8
) (
    input  logic       clk_model,
    input  logic       rst_n,
    input  logic [7:0] action,
    input  logic [7:0] emotional_state,
    input  logic [1:0] development_stage,
    input  logic [3:0] alarm,
    speech_arbiter_if.master talk
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_COOL} state_t;

    localparam logic [1:0] SRC_ALARM = 2'd0;
    localparam logic [1:0] SRC_ACT   = 2'd1;
    localparam logic [1:0] SRC_EMO   = 2'd2;
    localparam logic [1:0] SRC_CHAT  = 2'd3;

    localparam logic [7:0] COOL_INIT = 8'(COOLDOWN);
    localparam logic [7:0] TMR_INIT  = 8'(REQ_TIMEOUT);
    localparam logic [7:0] CHAT_TC   = 8'(PERIODIC - 1);

    state_t      state, state_nxt;
    logic        busy_m, busy_s;
    logic [7:0]  prev_action, prev_emotion;
    logic        primed;
    logic [3:0]  alarm_prev;
    logic [3:0]  pend_alarm;
    logic        pend_act, pend_emo, pend_chat;
    logic [7:0]  chat_cnt;
    logic [7:0]  cool_cnt, cool_nxt;
    logic [7:0]  req_tmr, tmr_nxt;
    logic        talk_req_q, req_nxt;
    logic [15:0] talk_addr_q;
    logic [1:0]  grant_src_q;
    logic        timeout_err_q, tmo_nxt;

    logic        grant;
    logic        any_pend;
    logic [1:0]  alarm_idx;
    logic [1:0]  src_sel;
    logic [7:0]  payload;
    logic [3:0]  alarm_rise, alarm_clr;
    logic        act_evt, emo_evt, chat_tc;

    assign talk.talk_req    = talk_req_q;
    assign talk.talk_addr   = talk_addr_q;
    assign talk.grant_src   = grant_src_q;
    assign talk.timeout_err = timeout_err_q;

    assign any_pend   = (|pend_alarm) | pend_act | pend_emo | pend_chat;
    assign act_evt    = primed && (action != prev_action);
    assign emo_evt    = primed && (emotional_state != prev_emotion);
    assign alarm_rise = alarm & ~alarm_prev;
    assign chat_tc    = (chat_cnt == CHAT_TC);
    assign alarm_clr  = (grant && src_sel == SRC_ALARM) ? (4'b0001 << alarm_idx) : 4'b0000;

    // Source selection; payload is the live input at the grant edge so coalesced events carry the latest value.
    always_comb begin
        alarm_idx = 2'd0;
        if (pend_alarm[3])      alarm_idx = 2'd3;
        else if (pend_alarm[2]) alarm_idx = 2'd2;
        else if (pend_alarm[1]) alarm_idx = 2'd1;

        src_sel = SRC_CHAT;
        payload = 8'h00;
        if (|pend_alarm) begin
            src_sel = SRC_ALARM;
            payload = {6'b0, alarm_idx};
        end else if (pend_act) begin
            src_sel = SRC_ACT;
            payload = action;
        end else if (pend_emo) begin
            src_sel = SRC_EMO;
            payload = emotional_state;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = talk_req_q;
        tmr_nxt   = req_tmr;
        cool_nxt  = cool_cnt;
        tmo_nxt   = timeout_err_q;
        grant     = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_pend) begin
                    grant     = 1'b1;
                    req_nxt   = 1'b1;
                    tmr_nxt   = TMR_INIT;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (busy_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = S_BUSY;
                end else if (req_tmr <= 8'd1) begin
                    req_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = req_tmr - 8'd1;
                end
            end
            S_BUSY: begin
                if (!busy_s) begin
                    if (COOLDOWN == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cool_nxt  = COOL_INIT;
                        state_nxt = S_COOL;
                    end
                end
            end
            S_COOL: begin
                cool_nxt = cool_cnt - 8'd1;
                if (cool_cnt <= 8'd1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_model or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            talk_req_q    <= 1'b0;
            talk_addr_q   <= 16'h0000;
            grant_src_q   <= 2'd0;
            timeout_err_q <= 1'b0;
            req_tmr       <= 8'd0;
            cool_cnt      <= 8'd0;
        end else begin
            state         <= state_nxt;
            talk_req_q    <= req_nxt;
            timeout_err_q <= tmo_nxt;
            req_tmr       <= tmr_nxt;
            cool_cnt      <= cool_nxt;
            if (grant) begin
                talk_addr_q <= {src_sel, development_stage, payload, 4'h0};
                grant_src_q <= src_sel;
            end
        end
    end

    // Event capture: a set on the same edge as the granting clear wins, so nothing is lost.
    always_ff @(posedge clk_model or negedge rst_n) begin
        if (!rst_n) begin
            busy_m       <= 1'b0;
            busy_s       <= 1'b0;
            prev_action  <= 8'h00;
            prev_emotion <= 8'h00;
            primed       <= 1'b0;
            alarm_prev   <= 4'b0000;
            pend_alarm   <= 4'b0000;
            pend_act     <= 1'b0;
            pend_emo     <= 1'b0;
            pend_chat    <= 1'b0;
            chat_cnt     <= 8'd0;
        end else begin
            busy_m       <= talk.talk_busy;
            busy_s       <= busy_m;
            prev_action  <= action;
            prev_emotion <= emotional_state;
            primed       <= 1'b1;
            alarm_prev   <= alarm;
            pend_alarm   <= (pend_alarm & ~alarm_clr) | alarm_rise;
            pend_act     <= (pend_act  & ~(grant && src_sel == SRC_ACT))  | act_evt;
            pend_emo     <= (pend_emo  & ~(grant && src_sel == SRC_EMO))  | emo_evt;
            pend_chat    <= (pend_chat & ~(grant && src_sel == SRC_CHAT)) | chat_tc;
            if (grant || chat_tc)
                chat_cnt <= 8'd0;
            else if (state == S_IDLE && !any_pend)
                chat_cnt <= chat_cnt + 8'd1;
        end
    end

endmodule
